// File: rtl/button_event_arbiter.sv
// Shared-tick button debouncer feeding a round-robin press-event arbiter.
// Debounced rising edges are queued per button and offered one at a time over valid/ready.
module button_event_arbiter #(
    parameter  int N_BTN        = 4,
    parameter  int TICK_DIV     = 1024,
    parameter  int STABLE_TICKS = 4,
    localparam int ID_W         = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    input  logic             evt_ready,
    output logic [N_BTN-1:0] overrun
);

    localparam int              DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]      CNT_LAST = 4'(STABLE_TICKS - 1);

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    state_t             state;
    logic [N_BTN-1:0]   sync_meta;
    logic [N_BTN-1:0]   sync;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [3:0]         cnt [N_BTN];
    logic [N_BTN-1:0]   rise;
    logic [N_BTN-1:0]   pending;
    logic [N_BTN-1:0]   grant_mask;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    sel_idx;
    logic               found;

    // Index arithmetic modulo N_BTN; N_BTN need not be a power of two.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_BTN) s -= N_BTN;
        return ID_W'(s);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync      <= sync_meta;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end

    // A rise is the tick on which a low debounced level finally flips high.
    always_comb begin
        rise = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rise[i] = tick && sync[i] && !btn_level[i] && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_level <= '0;
            for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    btn_level[i] <= sync[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_BTN; k++) begin
            cand = wrap_idx(rr_ptr, k);
            if (!found && pending[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign grant_mask = (state == S_IDLE && found) ? ({{(N_BTN-1){1'b0}}, 1'b1} << sel_idx) : '0;

    // A new rise on the button being granted re-arms it rather than counting as lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= (pending & ~grant_mask) | rise;
            overrun <= overrun | (rise & pending & ~grant_mask);
        end
    end

    // Handshake: evt_valid/evt_id stay frozen until a clk edge with evt_valid && evt_ready;
    // evt_valid drops on the next cycle, so at most one event transfers every two cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        evt_id    <= sel_idx;
                        evt_valid <= 1'b1;
                        state     <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        rr_ptr    <= wrap_idx(evt_id, 1);
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: debounce, round-robin order, backpressure, overrun, reset.
module tb_button_event_arbiter;
  localparam int N_BTN = 4;
  localparam int ID_W  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_BTN-1:0] btn_raw = '0;
  logic [N_BTN-1:0] btn_level;
  logic             evt_valid;
  logic [ID_W-1:0]  evt_id;
  logic             evt_ready = 1'b0;
  logic [N_BTN-1:0] overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int n_evt   = 0;
  logic [ID_W-1:0] exp_q[$];

  logic stall_watch = 1'b0;
  logic stall_bad   = 1'b0;
  logic lvl_watch   = 1'b0;
  logic lvl_seen    = 1'b0;

  button_event_arbiter #(
    .N_BTN(N_BTN),
    .TICK_DIV(4),
    .STABLE_TICKS(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_id(evt_id),
    .evt_ready(evt_ready),
    .overrun(overrun)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every transfer must match the head of exp_q
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      n_evt++;
      check("evt_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("evt_id", 32'(evt_id), 32'(exp_q.pop_front()));
    end
    if (stall_watch && !(evt_valid === 1'b1 && evt_id === 2'd1)) stall_bad = 1'b1;
    if (lvl_watch && btn_level[1] === 1'b1) lvl_seen = 1'b1;
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    cyc(n);
    rst_n = 1'b1;
  endtask

  task automatic wait_level(input int b, input logic v, input int budget, input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (btn_level[b] === v) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (evt_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic drain(input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int evt_base;
    logic quiet;

    // reset values with all buttons pressed
    rst_n   = 1'b0;
    btn_raw = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {21'd0, btn_level, evt_valid, evt_id, overrun}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (evt_valid !== 1'b0) quiet = 1'b0;
    end
    check("no_evt_after_reset", 32'(quiet), 32'd1);
    @(posedge clk);
    #1;
    btn_raw = '0;
    cyc(20);
    check("level_after_short_hold", 32'(btn_level), 32'd0);

    // clean press of button 2
    evt_ready = 1'b1;
    evt_base  = n_evt;
    exp_q.push_back(2'd2);
    btn_raw[2] = 1'b1;
    wait_level(2, 1'b1, 15, "clean_level_rise");
    check("clean_valid_not_yet", 32'(evt_valid), 32'd0);
    @(negedge clk);
    check("clean_valid_offer", {evt_valid, 1'b0, evt_id}, {1'b1, 1'b0, 2'd2});
    @(negedge clk);
    check("clean_valid_one_cycle", 32'(evt_valid), 32'd0);
    @(posedge clk);
    #1;
    btn_raw[2] = 1'b0;
    wait_level(2, 1'b0, 15, "clean_level_fall");
    cyc(8);
    check("clean_event_count", 32'(n_evt - evt_base), 32'd1);

    // bounce rejection on button 1
    evt_base  = n_evt;
    lvl_watch = 1'b1;
    repeat (5) begin
      btn_raw[1] = 1'b1;
      cyc(6);
      btn_raw[1] = 1'b0;
      cyc(4);
    end
    cyc(16);
    lvl_watch = 1'b0;
    check("bounce_level", 32'(lvl_seen), 32'd0);
    check("bounce_events", 32'(n_evt - evt_base), 32'd0);

    // round-robin: 0+3 from rr_ptr 0, then 0 alone, then 0+3 from rr_ptr 1
    do_reset(2);
    evt_ready = 1'b1;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd3);
    btn_raw = 4'b1001;
    drain(30, "rr_first_pair");
    btn_raw = '0;
    cyc(20);
    exp_q.push_back(2'd0);
    btn_raw = 4'b0001;
    drain(30, "rr_single_0");
    btn_raw = '0;
    cyc(20);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    btn_raw = 4'b1001;
    drain(30, "rr_second_pair");
    btn_raw = '0;
    cyc(20);

    // backpressure and overrun on button 1
    evt_ready  = 1'b0;
    btn_raw[1] = 1'b1;
    wait_valid(20, "bp_first_offer");
    check("bp_offer_id", 32'(evt_id), 32'd1);
    stall_watch = 1'b1;
    btn_raw[1] = 1'b0;
    wait_level(1, 1'b0, 16, "bp_release_1");
    btn_raw[1] = 1'b1;
    wait_level(1, 1'b1, 16, "bp_repress_1");
    check("bp_no_overrun_yet", 32'(overrun), 32'd0);
    btn_raw[1] = 1'b0;
    wait_level(1, 1'b0, 16, "bp_release_2");
    btn_raw[1] = 1'b1;
    wait_level(1, 1'b1, 16, "bp_repress_2");
    check("bp_overrun_set", 32'(overrun), 32'h2);
    cyc(3);
    stall_watch = 1'b0;
    check("bp_stall_stable", 32'(stall_bad), 32'd0);
    evt_base = n_evt;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
    evt_ready = 1'b1;
    drain(10, "bp_drain");
    cyc(6);
    check("bp_event_count", 32'(n_evt - evt_base), 32'd2);
    check("bp_overrun_sticky", 32'(overrun), 32'h2);
    btn_raw = '0;
    cyc(20);

    // reset while an event is held offered
    evt_ready = 1'b0;
    btn_raw   = 4'b0100;
    wait_valid(20, "mid_offer_valid");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_reset_valid", 32'(evt_valid), 32'd0);
    check("mid_reset_overrun", 32'(overrun), 32'd0);
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (evt_valid !== 1'b0) quiet = 1'b0;
    end
    check("mid_reset_requalify", 32'(quiet), 32'd1);
    exp_q.push_back(2'd2);
    evt_ready = 1'b1;
    drain(30, "mid_reset_new_event");
    btn_raw = '0;
    cyc(20);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
